// File: rtl/audio_pkg.sv
// Shared definitions for the audio capture/playback controller:
// capture FSM encoding, default sample width and latency counter helpers.
package audio_pkg;

    localparam int AUDIO_DW  = 24;
    localparam int LAT_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_PUSH = 2'd2
    } cap_state_e;

    // Terminal value of the filter latency counter for a given latency.
    function automatic logic [LAT_CNT_W-1:0] lat_last(input int filt_lat);
        return LAT_CNT_W'(filt_lat - 1);
    endfunction

endpackage

// File: rtl/stereo_fifo.sv
// Synchronous FIFO of packed stereo entries {left, right}; a push while full
// is accepted only when a pop happens on the same edge.
module stereo_fifo #(
    parameter int EW    = 48,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [EW-1:0]            din,
    output logic [EW-1:0]            dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ZERO = AW'(0);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push_s, do_pop_s;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        do_pop_s  = pop && (count_q != CNT_ZERO);
        do_push_s = push && ((count_q != CNT_FULL) || do_pop_s);
        mem_d     = mem_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '{default: {EW{1'b0}}};
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
            count_q  <= CNT_ZERO;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == CNT_ZERO);
    assign count = count_q;

endmodule

// File: rtl/audio_stream_ctrl.sv
// Codec ADC capture -> external filter -> stereo FIFO -> codec DAC playback.
// Capture FSM and the independent DAC write side live here.
module audio_stream_ctrl
    import audio_pkg::*;
#(
    parameter int DW       = AUDIO_DW,
    parameter int DEPTH    = 4,
    parameter int FILT_LAT = 1
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic                   read_ready,
    input  logic [DW-1:0]          readdata_left,
    input  logic [DW-1:0]          readdata_right,
    output logic                   read,
    output logic [DW-1:0]          sample_left,
    output logic [DW-1:0]          sample_right,
    output logic                   sample_valid,
    input  logic [DW-1:0]          filt_left,
    input  logic [DW-1:0]          filt_right,
    input  logic                   write_ready,
    output logic                   write,
    output logic [DW-1:0]          writedata_left,
    output logic [DW-1:0]          writedata_right,
    output logic [$clog2(DEPTH):0] fill_level,
    output logic                   overflow
);

    localparam logic [LAT_CNT_W-1:0] LAT_LAST = lat_last(FILT_LAT);
    localparam logic [LAT_CNT_W-1:0] LAT_ZERO = LAT_CNT_W'(0);
    localparam logic [LAT_CNT_W-1:0] LAT_ONE  = LAT_CNT_W'(1);

    cap_state_e             state_q, state_d;
    logic [LAT_CNT_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic                   read_q, read_d;
    logic                   sample_valid_q, sample_valid_d;
    logic [DW-1:0]          sample_left_q, sample_left_d;
    logic [DW-1:0]          sample_right_q, sample_right_d;
    logic                   write_q, write_d;
    logic [DW-1:0]          wdata_left_q, wdata_left_d;
    logic [DW-1:0]          wdata_right_q, wdata_right_d;
    logic                   overflow_q, overflow_d;

    logic                   push_s, pop_s, full_s, empty_s;
    logic [2*DW-1:0]        head_s;
    logic [$clog2(DEPTH):0] count_s;

    stereo_fifo #(
        .EW    (2*DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLOCK_50),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .din   ({filt_left, filt_right}),
        .dout  (head_s),
        .full  (full_s),
        .empty (empty_s),
        .count (count_s)
    );

    // Capture FSM and DAC write side next-state logic.
    always_comb begin
        state_d        = state_q;
        lat_cnt_d      = lat_cnt_q;
        read_d         = 1'b0;
        sample_valid_d = 1'b0;
        sample_left_d  = sample_left_q;
        sample_right_d = sample_right_q;
        overflow_d     = overflow_q;
        push_s         = 1'b0;

        // Write side pops at most every other cycle so write never stays high.
        pop_s = write_ready && !empty_s && !write_q;
        write_d = pop_s;
        if (pop_s) begin
            {wdata_left_d, wdata_right_d} = head_s;
        end else begin
            wdata_left_d  = wdata_left_q;
            wdata_right_d = wdata_right_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (read_ready) begin
                    read_d         = 1'b1;
                    sample_valid_d = 1'b1;
                    sample_left_d  = readdata_left;
                    sample_right_d = readdata_right;
                    lat_cnt_d      = LAT_ZERO;
                    state_d        = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (lat_cnt_q == LAT_LAST) begin
                    state_d = ST_PUSH;
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_ONE;
                end
            end
            ST_PUSH: begin
                state_d = ST_IDLE;
                // A same-edge pop frees the slot, so full alone is not a drop.
                if (!full_s || pop_s) begin
                    push_s = 1'b1;
                end else begin
                    overflow_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller registers with synchronous reset.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            lat_cnt_q      <= LAT_ZERO;
            read_q         <= 1'b0;
            sample_valid_q <= 1'b0;
            sample_left_q  <= {DW{1'b0}};
            sample_right_q <= {DW{1'b0}};
            write_q        <= 1'b0;
            wdata_left_q   <= {DW{1'b0}};
            wdata_right_q  <= {DW{1'b0}};
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            lat_cnt_q      <= lat_cnt_d;
            read_q         <= read_d;
            sample_valid_q <= sample_valid_d;
            sample_left_q  <= sample_left_d;
            sample_right_q <= sample_right_d;
            write_q        <= write_d;
            wdata_left_q   <= wdata_left_d;
            wdata_right_q  <= wdata_right_d;
            overflow_q     <= overflow_d;
        end
    end

    assign read            = read_q;
    assign sample_valid    = sample_valid_q;
    assign sample_left     = sample_left_q;
    assign sample_right    = sample_right_q;
    assign write           = write_q;
    assign writedata_left  = wdata_left_q;
    assign writedata_right = wdata_right_q;
    assign fill_level      = count_s;
    assign overflow        = overflow_q;

endmodule

// File: tb/tb_audio_stream_ctrl.sv
// Self-checking bench: randomized codec traffic against a transaction-level
// queue model of capture timing, FIFO occupancy, overflow and playback order.
module tb_audio_stream_ctrl;

    localparam int DW       = 24;
    localparam int DEPTH    = 4;
    localparam int FILT_LAT = 1;

    logic          CLOCK_50 = 1'b0;
    logic          reset = 1'b0;
    logic          read_ready = 1'b0;
    logic [DW-1:0] readdata_left = '0, readdata_right = '0;
    logic          read, sample_valid, write, overflow;
    logic [DW-1:0] sample_left, sample_right, writedata_left, writedata_right;
    logic [DW-1:0] filt_left = '0, filt_right = '0;
    logic          write_ready = 1'b0;
    logic [2:0]    fill_level;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [2*DW-1:0] m_q[$];
    logic [2*DW-1:0] m_pend;
    int              m_busy = 0;
    int              m_ncap = 0;
    logic            m_ovf = 1'b0;
    logic            exp_read = 1'b0, exp_sv = 1'b0, exp_write = 1'b0;
    logic [DW-1:0]   exp_sl = '0, exp_sr = '0, exp_wl = '0, exp_wr = '0;
    logic [2:0]      exp_fill = 3'd0;

    audio_stream_ctrl #(.DW(DW), .DEPTH(DEPTH), .FILT_LAT(FILT_LAT)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .read_ready(read_ready),
        .readdata_left(readdata_left), .readdata_right(readdata_right),
        .read(read), .sample_left(sample_left), .sample_right(sample_right),
        .sample_valid(sample_valid), .filt_left(filt_left), .filt_right(filt_right),
        .write_ready(write_ready), .write(write), .writedata_left(writedata_left),
        .writedata_right(writedata_right), .fill_level(fill_level), .overflow(overflow)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Downstream filter model: one-cycle latency, output = input >> 3.
    always @(posedge CLOCK_50) begin
        if (sample_valid) begin
            filt_left  <= sample_left >> 3;
            filt_right <= sample_right >> 3;
        end
    end

    // Advance one clock: update the model from the inputs seen at the edge,
    // then return at the falling edge where outputs are compared and inputs driven.
    task automatic tick();
        logic pop, do_push;
        @(posedge CLOCK_50);
        if (reset) begin
            m_q.delete();
            m_busy = 0; m_ovf = 1'b0;
            exp_read = 1'b0; exp_sv = 1'b0; exp_write = 1'b0;
            exp_sl = '0; exp_sr = '0; exp_wl = '0; exp_wr = '0;
        end else begin
            exp_read = 1'b0; exp_sv = 1'b0;
            pop     = (m_q.size() > 0) && write_ready && !exp_write;
            do_push = (m_busy == 1);
            if (m_busy > 0) begin
                m_busy--;
            end else if (read_ready) begin
                exp_read = 1'b1; exp_sv = 1'b1;
                exp_sl = readdata_left; exp_sr = readdata_right;
                m_pend = {readdata_left >> 3, readdata_right >> 3};
                m_busy = FILT_LAT + 1;
                m_ncap++;
            end
            exp_write = pop;
            if (pop) {exp_wl, exp_wr} = m_q.pop_front();
            if (do_push) begin
                if (m_q.size() < DEPTH) m_q.push_back(m_pend);
                else m_ovf = 1'b1;
            end
        end
        exp_fill = 3'(m_q.size());
        @(negedge CLOCK_50);
    endtask

    task automatic test_reset();
        reset = 1'b1; tick(); tick();
        checks++;
        if ({read, sample_valid, write, overflow, fill_level} !== 7'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got r=%b sv=%b w=%b ovf=%b fill=%0d, want all 0",
                     read, sample_valid, write, overflow, fill_level);
        end
        checks++;
        if ({sample_left, sample_right, writedata_left, writedata_right} !== {4*DW{1'b0}}) begin
            errors++;
            $display("FAIL reset_data: got %h %h %h %h, want 0", sample_left, sample_right,
                     writedata_left, writedata_right);
        end
        reset = 1'b0; tick();
    endtask

    task automatic test_single();
        write_ready = 1'b1;
        read_ready = 1'b1; readdata_left = 24'h000100; readdata_right = DW'($urandom);
        tick();
        read_ready = 1'b0; readdata_left = DW'($urandom);
        checks++;
        if ({read, sample_valid, sample_left} !== {1'b1, 1'b1, 24'h000100}) begin
            errors++;
            $display("FAIL single_capture: got r=%b sv=%b sl=%h, want 1 1 000100",
                     read, sample_valid, sample_left);
        end
        tick();
        checks++;
        if ({read, sample_valid, fill_level} !== {1'b0, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL single_wait: got r=%b sv=%b fill=%0d, want 0 0 0", read, sample_valid, fill_level);
        end
        tick();
        checks++;
        if (fill_level !== 3'd1) begin
            errors++;
            $display("FAIL single_push: fill got %0d want 1", fill_level);
        end
        tick();
        checks++;
        if ({write, writedata_left, fill_level} !== {1'b1, 24'h000020, 3'd0}) begin
            errors++;
            $display("FAIL single_write: got w=%b wl=%h fill=%0d, want 1 000020 0",
                     write, writedata_left, fill_level);
        end
        tick();
        checks++;
        if (write !== 1'b0) begin
            errors++;
            $display("FAIL single_write_pulse: write got %b want 0", write);
        end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] vals[5];
        int k = 0;
        reset = 1'b1; tick(); reset = 1'b0; write_ready = 1'b0; tick();
        for (int c = 0; c < 5; c++) begin
            vals[c] = DW'($urandom);
            read_ready = 1'b1; readdata_left = vals[c]; readdata_right = DW'($urandom);
            tick(); read_ready = 1'b0; tick(); tick();
            checks++;
            if ({overflow, fill_level} !== {m_ovf, exp_fill}) begin
                errors++;
                $display("FAIL ovf_fill[%0d]: got ovf=%b fill=%0d, want %b %0d",
                         c, overflow, fill_level, m_ovf, exp_fill);
            end
        end
        checks++;
        if ({overflow, fill_level} !== {1'b1, 3'd4}) begin
            errors++;
            $display("FAIL ovf_final: got ovf=%b fill=%0d, want 1 4", overflow, fill_level);
        end
        write_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (write) begin
                checks++;
                if (k > 3 || writedata_left !== (vals[k] >> 3)) begin
                    errors++;
                    $display("FAIL ovf_drain[%0d]: got %h want %h", k, writedata_left,
                             (k > 3) ? {DW{1'b0}} : (vals[k] >> 3));
                end
                k++;
            end
        end
        checks++;
        if (k != 4 || fill_level !== 3'd0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_drain_count: got writes=%0d fill=%0d ovf=%b, want 4 0 1",
                     k, fill_level, overflow);
        end
    endtask

    task automatic test_simul();
        reset = 1'b1; tick(); reset = 1'b0; write_ready = 1'b0; tick();
        read_ready = 1'b1;
        for (int e = 0; e <= 12; e++) begin
            readdata_left = DW'($urandom); readdata_right = DW'($urandom);
            tick();
        end
        read_ready = 1'b0;
        tick();
        write_ready = 1'b1;
        tick();
        write_ready = 1'b0;
        checks++;
        if ({write, overflow, fill_level} !== {1'b1, 1'b0, 3'd4}) begin
            errors++;
            $display("FAIL simul_push_pop: got w=%b ovf=%b fill=%0d, want 1 0 4",
                     write, overflow, fill_level);
        end
        checks++;
        if ({writedata_left, writedata_right, fill_level} !== {exp_wl, exp_wr, exp_fill}) begin
            errors++;
            $display("FAIL simul_model: got %h %h fill=%0d, want %h %h %0d",
                     writedata_left, writedata_right, fill_level, exp_wl, exp_wr, exp_fill);
        end
    endtask

    task automatic test_continuous();
        int   nwr = 0;
        logic prev_w = 1'b0;
        reset = 1'b1; tick(); reset = 1'b0; tick();
        m_ncap = 0;
        read_ready = 1'b1; write_ready = 1'b1;
        for (int i = 0; i < 400 && nwr < 100; i++) begin
            readdata_left = DW'($urandom); readdata_right = DW'($urandom);
            tick();
            if (m_ncap >= 100) read_ready = 1'b0;
            checks++;
            if ({read, sample_valid, write, overflow, fill_level, writedata_left, writedata_right} !==
                {exp_read, exp_sv, exp_write, m_ovf, exp_fill, exp_wl, exp_wr}) begin
                errors++;
                $display("FAIL cont[%0d]: got r=%b sv=%b w=%b ovf=%b fill=%0d wd=%h/%h, want %b %b %b %b %0d %h/%h",
                         i, read, sample_valid, write, overflow, fill_level, writedata_left,
                         writedata_right, exp_read, exp_sv, exp_write, m_ovf, exp_fill, exp_wl, exp_wr);
            end
            if (write && prev_w) begin
                errors++;
                $display("FAIL cont_back_to_back: write high on consecutive cycles at %0d", i);
            end
            prev_w = write;
            if (write) nwr++;
        end
        read_ready = 1'b0;
        checks++;
        if (nwr != 100 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL cont_total: got writes=%0d ovf=%b, want 100 0", nwr, overflow);
        end
    endtask

    task automatic test_reset_mid();
        logic saw_w = 1'b0;
        reset = 1'b1; tick(); reset = 1'b0; write_ready = 1'b0; tick();
        read_ready = 1'b1;
        for (int e = 0; e <= 6; e++) begin
            readdata_left = DW'($urandom); readdata_right = DW'($urandom);
            tick();
        end
        read_ready = 1'b0;
        checks++;
        if (fill_level !== 3'd2) begin
            errors++;
            $display("FAIL rstmid_pre: fill got %0d want 2", fill_level);
        end
        write_ready = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({fill_level, write, read} !== {3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rstmid_after: got fill=%0d w=%b r=%b, want 0 0 0", fill_level, write, read);
        end
        tick(); tick();
        read_ready = 1'b1; readdata_left = DW'($urandom); readdata_right = DW'($urandom);
        tick();
        read_ready = 1'b0;
        checks++;
        if ({read, sample_valid, sample_left, sample_right} !== {1'b1, 1'b1, exp_sl, exp_sr}) begin
            errors++;
            $display("FAIL rstmid_capture: got r=%b sv=%b s=%h/%h, want 1 1 %h/%h",
                     read, sample_valid, sample_left, sample_right, exp_sl, exp_sr);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (write) saw_w = 1'b1;
            checks++;
            if ({write, fill_level, writedata_left, writedata_right} !== {exp_write, exp_fill, exp_wl, exp_wr}) begin
                errors++;
                $display("FAIL rstmid_flow[%0d]: got w=%b fill=%0d wd=%h/%h, want %b %0d %h/%h",
                         i, write, fill_level, writedata_left, writedata_right,
                         exp_write, exp_fill, exp_wl, exp_wr);
            end
        end
        checks++;
        if (!saw_w) begin
            errors++;
            $display("FAIL rstmid_write_seen: got no write, want one write");
        end
    endtask

    task automatic test_empty();
        logic [DW-1:0] hold_l, hold_r;
        hold_l = exp_wl; hold_r = exp_wr;
        write_ready = 1'b1; read_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            readdata_left = DW'($urandom);
            tick();
            checks++;
            if ({write, fill_level, writedata_left, writedata_right} !== {1'b0, 3'd0, hold_l, hold_r}) begin
                errors++;
                $display("FAIL empty[%0d]: got w=%b fill=%0d wd=%h/%h, want 0 0 %h/%h",
                         i, write, fill_level, writedata_left, writedata_right, hold_l, hold_r);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_simul();
        test_continuous();
        test_reset_mid();
        test_empty();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/audio_stream_ctrl.md
AUDIO_STREAM_CTRL -- requirements
Module: audio_stream_ctrl

Interface
REQ-001 Parameter DW, default 24: sample width per channel in bits.
REQ-002 Parameter DEPTH, default 4: output FIFO depth in stereo entries, power of two, at least 2.
REQ-003 Parameter FILT_LAT, default 1: cycles from sample_valid to valid filt_left/filt_right, range 1..15.
REQ-004 CLOCK_50  input  1  system clock; the only clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 read_ready  input  1  codec has a stereo ADC sample available.
REQ-007 readdata_left, readdata_right  input  DW each  codec ADC samples.
REQ-008 read  output  1  one-cycle pop strobe to the codec ADC FIFO.
REQ-009 sample_left, sample_right  output  DW each  held ADC sample presented to the downstream filter.
REQ-010 sample_valid  output  1  one-cycle strobe; sample_* are new this cycle; drives the filter shift enable.
REQ-011 filt_left, filt_right  input  DW each  filter result for the last sample.
REQ-012 write_ready  input  1  codec DAC FIFO can accept a stereo sample.
REQ-013 write  output  1  one-cycle push strobe to the codec DAC FIFO.
REQ-014 writedata_left, writedata_right  output  DW each  registered DAC samples.
REQ-015 fill_level  output  log2(DEPTH)+1  current FIFO occupancy.
REQ-016 overflow  output  1  sticky flag; a filter result was dropped.

Function
REQ-017 Capture FSM states are IDLE, WAIT and PUSH.
REQ-018 In IDLE with read_ready=1, the edge loads sample_* from readdata_*, registers read=1 and sample_valid=1 for one cycle, clears the latency counter, and moves to WAIT.
REQ-019 In IDLE with read_ready=0, the FSM holds and read and sample_valid stay 0.
REQ-020 WAIT counts FILT_LAT cycles after sample_valid, then moves to PUSH; read_ready is ignored outside IDLE.
REQ-021 PUSH writes {filt_left, filt_right} to the FIFO tail when the FIFO is not full, then returns to IDLE after exactly one cycle.
REQ-022 A PUSH with the FIFO full discards the data, sets overflow=1, and leaves FIFO contents and fill_level unchanged.
REQ-023 Minimum capture period is FILT_LAT+2 cycles from read to the next read.
REQ-024 The write side is independent of the capture FSM.
REQ-025 When fill_level>0, write_ready=1 and write=0, the edge loads writedata_* from the FIFO head, registers write=1 and pops the head.
REQ-026 write is never high on two consecutive cycles.
REQ-027 writedata_* hold their value until the next write.
REQ-028 A push and a pop on the same edge both take effect and fill_level stays unchanged; push-while-full with a simultaneous pop is accepted and is not an overflow.
REQ-029 Read and write pointers wrap modulo DEPTH; fill_level ranges from 0 to DEPTH.
REQ-030 With the FIFO empty, write stays 0 regardless of write_ready, and writedata_* hold their value.
REQ-031 Samples pass through unmodified, with no sign or width change; output order equals capture order.

Reset
REQ-032 reset=1 forces FSM to IDLE, pointers to 0, fill_level=0, read=0, write=0, sample_valid=0, overflow=0, sample_*=0 and writedata_*=0 on the next edge.
REQ-033 Reset asserted mid-WAIT or mid-PUSH abandons the sample in flight; no FIFO write occurs.
REQ-034 Reset takes priority over every other event on the same edge.
REQ-035 overflow clears only on reset.

Structure
REQ-036 FSM state encoding and the DW default are defined in shared package audio_pkg.
REQ-037 The FIFO is one sub-module, stereo_fifo, holding 2*DW-bit entries and providing push, pop, full, empty and count.
REQ-038 The capture FSM and write-side logic are implemented in audio_stream_ctrl itself.

Verification
REQ-039 Scenario single sample: FILT_LAT=1; read_ready pulses with readdata_left=24'h000100; filter model returns input>>3 -> read high one cycle, sample_valid high one cycle, 24'h000020 pushed 2 cycles after sample_valid, write pulses with writedata_left=24'h000020.
REQ-040 Scenario overflow: write_ready held 0; 5 captures with DEPTH=4 -> fill_level=4, overflow=1 after the 5th PUSH; releasing write_ready drains the first 4 samples in order.
REQ-041 Scenario simultaneous push/pop: fill_level=4 and write_ready=1 on the PUSH edge -> fill_level stays 4, overflow stays 0.
REQ-042 Scenario continuous traffic: read_ready and write_ready tied 1 for 100 captures -> 100 writes, no overflow, data order preserved, never two consecutive write cycles.
REQ-043 Scenario reset mid-operation: reset asserted during WAIT with fill_level=2 -> next cycle fill_level=0, no write, and the following capture starts cleanly from IDLE.
REQ-044 Scenario empty: write_ready=1 with the FIFO empty for 20 cycles -> write stays 0 and writedata_* unchanged.
